// File: rtl/key_debounce.sv
// key_debounce
// ------------
// Conditions the raw board switch/button lines before they reach the Keyboard
// device register. Each line passes through a two-flop synchroniser. It is then
// sampled once per tick (every TICK_DIV clocks). A new level is accepted only
// after STABLE_N consecutive equal samples. A sticky per-bit change mask and a
// level interrupt let the CPU poll for key activity or take an interrupt on it.
//
// Parameters
//   WIDTH      number of key lines
//   TICK_DIV   clocks per sample tick (>= 1)
//   STABLE_N   consecutive equal samples needed to accept a level (>= 2)
//   ACTIVE_LOW invert the synchronised input before debouncing
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst       asynchronous, active-high reset
//   key_raw   raw asynchronous key levels
//   clr_en    write strobe for clearing change-mask bits
//   clr_mask  bits written 1 clear the matching chg_mask bit while clr_en=1
//   key_out   debounced key levels (registered)
//   key_chg   one-cycle pulse on the cycle any key_out bit changes (registered)
//   chg_mask  sticky "changed since last clear" flags (registered)
//   key_irq   OR of chg_mask (level interrupt, driven from registers only)

module key_debounce #(
    parameter int WIDTH      = 32,
    parameter int TICK_DIV   = 4,
    parameter int STABLE_N   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key_raw,
    input  logic             clr_en,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] key_out,
    output logic             key_chg,
    output logic [WIDTH-1:0] chg_mask,
    output logic             key_irq
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] samp;
    logic [CNT_W-1:0] div_cnt_reg;
    logic [CNT_W-1:0] div_cnt_next;
    logic             tick;

    logic [WIDTH-1:0] key_out_reg;
    logic [WIDTH-1:0] key_out_next;
    logic             key_chg_reg;
    logic [WIDTH-1:0] chg_mask_reg;
    logic [WIDTH-1:0] chg_mask_next;
    logic [WIDTH-1:0] toggle_bits;

    // Two-flop synchroniser against metastability on the asynchronous pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= key_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign samp = ACTIVE_LOW ? ~sync2_reg : sync2_reg;

    // Sample-tick divider. It wraps straight from TICK_DIV-1 to 0, so the tick
    // period is exactly TICK_DIV clocks. With TICK_DIV=1 the counter stays at 0
    // and tick is asserted on every cycle.
    assign tick         = (div_cnt_reg == CNT_LAST);
    assign div_cnt_next = tick ? '0 : div_cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    // Per-bit sample history and accept logic. Each bit is independent. A
    // level is accepted only when the whole history window agrees, so a single
    // differing sample holds the current output.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [STABLE_N-1:0] hist_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hist_reg <= '0;
            end else if (tick) begin
                hist_reg <= {hist_reg[STABLE_N-2:0], samp[gi]};
            end
        end

        assign key_out_next[gi] = (&hist_reg)  ? 1'b1 :
                                  (~|hist_reg) ? 1'b0 :
                                                 key_out_reg[gi];
    end

    assign toggle_bits = key_out_next ^ key_out_reg;

    // A new toggle takes priority over a clear issued in the same cycle, so no
    // key event can be lost.
    assign chg_mask_next = (chg_mask_reg & ~(clr_mask & {WIDTH{clr_en}})) | toggle_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_out_reg  <= '0;
            key_chg_reg  <= 1'b0;
            chg_mask_reg <= '0;
        end else begin
            key_out_reg  <= key_out_next;
            key_chg_reg  <= |toggle_bits;
            chg_mask_reg <= chg_mask_next;
        end
    end

    assign key_out  = key_out_reg;
    assign key_chg  = key_chg_reg;
    assign chg_mask = chg_mask_reg;
    assign key_irq  = |chg_mask_reg;

endmodule

// File: doc/key_debounce.md
# key_debounce

Input conditioning stage between the raw board switch/button pins and the Keyboard device register. It synchronises the 32 raw key lines to the 1 kHz system clock and debounces each bit by repeated sampling. The resulting stable `key_out` word feeds the Keyboard device's `KeyIn`. It also keeps a sticky per-bit change mask and a level interrupt request, so the CPU can poll or take an interrupt on key activity.

## Interface
- `WIDTH`, 32, number of key lines (`{user1,user2,user3,user4}` packed MSB first)
- `TICK_DIV`, 4, clocks per sample tick (≥1); 4 ms sampling at `clk` = 1 kHz
- `STABLE_N`, 4, consecutive equal samples required to accept a new level (≥2)
- `ACTIVE_LOW`, 0, when 1 the synchronised input is inverted before debouncing
- `clk`  in  1  system clock (`clk_1kHz` at top level); all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `key_raw`  in  WIDTH  raw, asynchronous switch/button levels
- `clr_en`  in  1  write strobe for clearing change-mask bits
- `clr_mask`  in  WIDTH  bits written 1 clear the matching `chg_mask` bit when `clr_en`=1
- `key_out`  out  WIDTH  debounced key levels, registered
- `key_chg`  out  1  one-cycle pulse on the cycle any `key_out` bit changes, registered
- `chg_mask`  out  WIDTH  sticky per-bit "changed since last clear" flags, registered
- `key_irq`  out  1  `|chg_mask` (level interrupt, driven from registers only)

## Operation
- Reset (async, immediate) clears the following to 0: `sync1`, `sync2`, `div_cnt`, every `hist[i]`, `key_out`, `key_chg`, `chg_mask`. `key_irq` is therefore 0.
- Synchroniser: `sync1 <= key_raw`; `sync2 <= sync1`. When `ACTIVE_LOW`=1, `samp = ~sync2`; otherwise `samp = sync2`.
- Tick counter: `div_cnt` counts 0..`TICK_DIV`-1 and wraps to 0. `tick` = (`div_cnt` == `TICK_DIV`-1). With `TICK_DIV`=1, `tick` is 1 every cycle.
- History: on each `tick`, `hist[i] <= {hist[i][STABLE_N-2:0], samp[i]}`. Outside a tick, `hist` holds.
- Per-bit accept: `key_out[i]` is updated every clock from registered `hist[i]`.
  - `hist[i]` all ones and `key_out[i]`=0: set `key_out[i]` to 1.
  - `hist[i]` all zeros and `key_out[i]`=1: set `key_out[i]` to 0.
  - Otherwise: hold.
  - A single differing sample breaks stability, so glitches shorter than one tick spacing that are caught by at most `STABLE_N`-1 samples never reach `key_out`.
- `key_chg <= |(next_key_out ^ key_out)`: high in the same cycle the new `key_out` value appears, for exactly one cycle.
- Change mask, per bit: `chg_mask[i] <= (chg_mask[i] & ~(clr_en & clr_mask[i])) | edge[i]`, where `edge[i]` = `key_out[i]` toggles this cycle.
  - Set and clear of the same bit in the same cycle: set wins (bit stays 1).
  - `clr_en`=1 with `clr_mask`=0 is a no-op.
- Bits are fully independent; any number may change in the same cycle.

## Timing
- Latency is counted from the rising edge at which `sync1` first captures a new raw level (edge E0). Input must be held stable after E0.
- `key_out` reflects the new level after edge E0+3+(`STABLE_N`-1)·`TICK_DIV` at the earliest and E0+2+`STABLE_N`·`TICK_DIV` at the latest. The spread depends on `div_cnt` phase.
- Defaults (`TICK_DIV`=4, `STABLE_N`=4): window is 15..18 edges after E0.
- `chg_mask[i]` and `key_chg` update on the same edge as `key_out[i]`. `key_irq` follows `chg_mask` combinationally, with no extra cycle.
- Clear latency: a `chg_mask` bit reads 0 on the edge after `clr_en`, unless a new edge on that bit occurs in that cycle.
- Reset asserted mid-debounce discards all history. After release, a held input requires a full new debounce window measured from the first post-reset capture.
- `div_cnt` wraps from `TICK_DIV`-1 to 0 without a gap, so the tick period is exactly `TICK_DIV` cycles.

## Test plan
- Reset then idle: `key_raw`=0 for 50 cycles → `key_out`=0, `chg_mask`=0, `key_irq`=0, `key_chg` never pulses.
- Clean press: `key_raw`=32'h0000_0001 held → `key_out`=32'h0000_0001 between edges 15 and 18 after capture. In that cycle `key_chg`=1 for one cycle, `chg_mask`=32'h1, `key_irq`=1. Release gives the symmetric result: `key_out`=0 and `chg_mask` stays 1.
- Bounce: bit 8 toggled every 3 cycles for 40 cycles, then held at 1 → `key_out[8]` stays 0 during bouncing, then rises within 18 edges of the last toggle capture. Exactly one `key_chg` pulse occurs.
- Multi-bit: 32'hFF00_00FF applied at once → all 16 bits rise on the same edge, with a single `key_chg` pulse and `chg_mask`=32'hFF00_00FF.
- Clear: `clr_en`=1 with `clr_mask`=32'h0000_00FF → `chg_mask`=32'hFF00_0000 next edge. A clear of bit 31 coinciding with a new bit 31 edge leaves bit 31 set.
- Reset mid-debounce: `rst` pulsed 10 edges after a press is captured → all outputs read 0 immediately. `key_out` rises 15..18 edges after the first post-reset capture.
